// File: rtl/spi_slave.sv
// spi_slave: SPI slave, all four CPOL/CPHA modes, configurable word length, back-to-back frames
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   cpol_i, cpha_i       SPI mode, latched at the start of each frame
//   din_i, load_i        transmit word and its one-cycle write strobe
//   dout_o, rx_valid_o   last received word and its one-cycle tick
//   busy_o               high while a frame is selected
//   sclk_i, ss_ni        SPI clock and active-low select, asynchronous to clk_i
//   mosi_i               serial data in
//   miso_o, miso_oe_o    serial data out (MSB first) and its tristate enable
module spi_slave #(
   parameter int WordLength = 24
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic [WordLength-1:0] din_i,
   input  logic                  load_i,
   output logic [WordLength-1:0] dout_o,
   output logic                  rx_valid_o,
   output logic                  busy_o,
   input  logic                  sclk_i,
   input  logic                  ss_ni,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o
);
   localparam int CW = $clog2(WordLength);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;

   logic ss_meta, ss_sync, ss_d;
   logic sclk_meta, sclk_sync, sclk_d;
   logic mosi_meta, mosi_sync;
   logic up, armed, cpol_q, cpha_q;
   logic [CW-1:0] bit_cnt;
   logic [WordLength-1:0] tx_buf, tx_sr, rx_next;
   logic [WordLength-2:0] rx_sr;
   logic ss_fall, ss_rise, sclk_edge, leading, trailing, sample, shift, start, stop, last;

   // A falling select only counts once the select has been seen high after
   // reset, so a select already low at release does not open a frame.
   assign ss_fall   = armed & ss_d & ~ss_sync;
   assign ss_rise   = ~ss_d & ss_sync;
   assign sclk_edge = sclk_sync ^ sclk_d;
   assign leading   = sclk_edge & (sclk_sync ^ cpol_q);
   assign trailing  = sclk_edge & ~(sclk_sync ^ cpol_q);
   assign sample    = busy_o & (cpha_q ? trailing : leading);
   assign shift     = busy_o & (cpha_q ? leading : trailing);
   assign start     = ~busy_o & ss_fall;
   assign stop      = busy_o & ss_rise;
   assign last      = bit_cnt == CW'(WordLength - 1);
   assign rx_next   = {rx_sr, mosi_sync};

   assign busy_o    = state_q == ACTIVE;
   assign miso_oe_o = busy_o;
   assign miso_o    = busy_o & tx_sr[WordLength-1];

   always_comb begin
      state_d = start ? ACTIVE : stop ? IDLE : state_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ss_meta    <= 1'b1;
         ss_sync    <= 1'b1;
         ss_d       <= 1'b1;
         sclk_meta  <= 1'b0;
         sclk_sync  <= 1'b0;
         sclk_d     <= 1'b0;
         mosi_meta  <= 1'b0;
         mosi_sync  <= 1'b0;
         up         <= 1'b0;
         armed      <= 1'b0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         bit_cnt    <= '0;
         tx_buf     <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         dout_o     <= '0;
         rx_valid_o <= 1'b0;
      end else begin
         ss_meta    <= ss_ni;
         ss_sync    <= ss_meta;
         ss_d       <= ss_sync;
         sclk_meta  <= sclk_i;
         sclk_sync  <= sclk_meta;
         sclk_d     <= sclk_sync;
         mosi_meta  <= mosi_i;
         mosi_sync  <= mosi_meta;
         // ss_meta carries a real pin sample only from the second cycle on
         up         <= 1'b1;
         armed      <= armed | (up & ss_meta);
         rx_valid_o <= 1'b0;
         if (load_i) tx_buf <= din_i;
         if (start) begin
            cpol_q  <= cpol_i;
            cpha_q  <= cpha_i;
            bit_cnt <= '0;
            tx_sr   <= tx_buf;
         end else if (stop) begin
            bit_cnt <= '0;
         end else begin
            if (sample) begin
               rx_sr   <= rx_next[WordLength-2:0];
               bit_cnt <= last ? '0 : bit_cnt + 1'b1;
               if (last) begin
                  dout_o     <= rx_next;
                  rx_valid_o <= 1'b1;
               end
            end
            if (shift) tx_sr <= (bit_cnt == '0) ? tx_buf : {tx_sr[WordLength-2:0], 1'b0};
         end
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master with an rx-word scoreboard for spi_slave
module tb_spi_slave;
   localparam int W = 24;
   localparam int H = 6;

   logic clk = 1'b0, rst_n = 1'b0, cpol = 1'b0, cpha = 1'b0, load = 1'b0;
   logic sclk = 1'b0, ss_n = 1'b0, mosi = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout;
   logic rx_valid, busy, miso, miso_oe;

   int tests = 0, fails = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_tx[2];
   logic [W-1:0] m_exp[2];
   int ld_bit = -2;
   logic [W-1:0] ld_val = '0;

   always #5 clk = ~clk;

   spi_slave #(.WordLength(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cpol_i(cpol), .cpha_i(cpha),
      .din_i(din), .load_i(load), .dout_o(dout), .rx_valid_o(rx_valid),
      .busy_o(busy), .sclk_i(sclk), .ss_ni(ss_n), .mosi_i(mosi),
      .miso_o(miso), .miso_oe_o(miso_oe)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got pulse with dout %h expected no pulse", dout);
         end else begin
            check("rx_word", 32'(dout), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL timeout: got no end of run expected $finish");
      $fatal(1, "timeout");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_word(input logic [W-1:0] v);
      din = v;
      load = 1'b1;
      wait_cyc(1);
      load = 1'b0;
      wait_cyc(1);
   endtask

   task automatic xfer_bit(input logic cp, input logic ch, input logic b, output logic m);
      if (!ch) begin
         mosi = b;
         wait_cyc(H);
         m = miso;
         sclk = ~cp;
         wait_cyc(H);
         sclk = cp;
      end else begin
         sclk = ~cp;
         mosi = b;
         wait_cyc(H);
         m = miso;
         sclk = cp;
         wait_cyc(H);
      end
   endtask

   task automatic frame(input logic cp, input logic ch, input int nw, input int abort);
      int nb;
      logic m;
      logic [W-1:0] got[2];
      nb = abort != 0 ? abort : nw * W;
      cpol = cp;
      cpha = ch;
      sclk = cp;
      wait_cyc(4);
      if (abort == 0) for (int w = 0; w < nw; w++) exp_q.push_back(m_tx[w]);
      ss_n = 1'b0;
      if (ld_bit == -1) begin
         wait_cyc(2);
         din = ld_val;
         load = 1'b1;
         wait_cyc(1);
         load = 1'b0;
         wait_cyc(H);
      end else begin
         wait_cyc(H + 3);
      end
      check("busy_active", 32'(busy), 1);
      check("oe_active", 32'(miso_oe), 1);
      for (int j = 0; j < nb; j++) begin
         if (j == ld_bit) begin
            din = ld_val;
            load = 1'b1;
            wait_cyc(1);
            load = 1'b0;
         end
         xfer_bit(cp, ch, m_tx[j / W][W - 1 - j % W], m);
         got[j / W][W - 1 - j % W] = m;
      end
      wait_cyc(H);
      ss_n = 1'b1;
      wait_cyc(8);
      check("busy_idle", 32'(busy), 0);
      check("miso_idle", 32'(miso), 0);
      if (abort == 0) for (int w = 0; w < nw; w++) check("miso_word", 32'(got[w]), 32'(m_exp[w]));
      ld_bit = -2;
   endtask

   initial begin
      logic m;
      @(negedge clk);
      wait_cyc(4);
      check("rst_dout", 32'(dout), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_miso", 32'(miso), 0);
      check("rst_miso_oe", 32'(miso_oe), 0);

      rst_n = 1'b1;
      wait_cyc(4);
      for (int i = 0; i < W; i++) xfer_bit(1'b0, 1'b0, 1'b1, m);
      check("busy_low_at_release", 32'(busy), 0);
      ss_n = 1'b1;
      wait_cyc(8);

      load_word(24'hA5C3F0);
      m_tx[0] = 24'h123456;
      m_exp[0] = 24'hA5C3F0;
      frame(1'b0, 1'b0, 1, 0);

      for (int md = 1; md < 4; md++) begin
         load_word(24'h800001);
         m_tx[0] = 24'h800001;
         m_exp[0] = 24'h800001;
         frame(md[1], md[0], 1, 0);
      end

      load_word(24'h111111);
      m_tx[0] = 24'hABCDEF;
      m_tx[1] = 24'h135790;
      m_exp[0] = 24'h111111;
      m_exp[1] = 24'h222222;
      ld_bit = 5;
      ld_val = 24'h222222;
      frame(1'b0, 1'b0, 2, 0);

      m_tx[0] = 24'h000000;
      frame(1'b0, 1'b0, 1, 10);
      check("dout_kept", 32'(dout), 32'h135790);
      m_tx[0] = 24'hFFFFFF;
      m_exp[0] = 24'h222222;
      frame(1'b0, 1'b0, 1, 0);

      ld_bit = -1;
      ld_val = 24'h3C3C3C;
      m_tx[0] = 24'h0A0B0C;
      m_tx[1] = 24'hC0B0A0;
      m_exp[0] = 24'h222222;
      m_exp[1] = 24'h3C3C3C;
      frame(1'b0, 1'b0, 2, 0);

      cpol = 1'b0;
      cpha = 1'b0;
      sclk = 1'b0;
      wait_cyc(4);
      ss_n = 1'b0;
      wait_cyc(H + 3);
      for (int i = 0; i < 8; i++) xfer_bit(1'b0, 1'b0, 1'b1, m);
      rst_n = 1'b0;
      #1;
      check("midrst_dout", 32'(dout), 0);
      check("midrst_rx_valid", 32'(rx_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_miso", 32'(miso), 0);
      check("midrst_miso_oe", 32'(miso_oe), 0);
      @(negedge clk);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);
      for (int i = 0; i < 2 * W - 8; i++) xfer_bit(1'b0, 1'b0, 1'b1, m);
      check("busy_after_midrst", 32'(busy), 0);
      wait_cyc(H);
      ss_n = 1'b1;
      wait_cyc(8);

      load_word(24'h5A5A5A);
      m_tx[0] = 24'h0F0F0F;
      m_exp[0] = 24'h5A5A5A;
      frame(1'b0, 1'b0, 1, 0);

      wait_cyc(20);
      check("rx_queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL expose parameter WordLength, default 24, giving the bits per SPI frame word (valid range 2..32).
REQ-002 The module SHALL have port clk_i, input, 1 bit: system clock, with all logic on its rising edge.
REQ-003 The module SHALL have port rst_ni, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 The module SHALL have port cpol_i, input, 1 bit: SPI clock idle level.
REQ-005 The module SHALL have port cpha_i, input, 1 bit: SPI clock phase (0 = sample on leading edge, 1 = sample on trailing edge).
REQ-006 The module SHALL have port din_i, input, WordLength bits: transmit word for the next frame.
REQ-007 The module SHALL have port load_i, input, 1 bit: one-cycle strobe that writes din_i into the transmit buffer.
REQ-008 The module SHALL have port dout_o, output, WordLength bits: last fully received word.
REQ-009 The module SHALL have port rx_valid_o, output, 1 bit: one-cycle tick marking a new dout_o.
REQ-010 The module SHALL have port busy_o, output, 1 bit: high while a frame is selected (state ACTIVE).
REQ-011 The module SHALL have port sclk_i, input, 1 bit: SPI clock from the master, asynchronous to clk_i.
REQ-012 The module SHALL have port ss_ni, input, 1 bit: active-low slave select, asynchronous.
REQ-013 The module SHALL have port mosi_i, input, 1 bit: serial data in from the master.
REQ-014 The module SHALL have port miso_o, output, 1 bit: serial data out, MSB first.
REQ-015 The module SHALL have port miso_oe_o, output, 1 bit: output enable for an external tristate driver on miso_o.

Function
REQ-016 sclk_i, ss_ni and mosi_i SHALL each pass through a 2-flop synchronizer, plus one extra register on sclk_i and ss_ni for edge detection.
REQ-017 Correct operation SHALL be guaranteed when the sclk_i high time and low time are each at least 4 clk_i periods.
REQ-018 State machine: IDLE -> ACTIVE on the synchronized ss_ni falling edge; ACTIVE -> IDLE on the synchronized ss_ni rising edge; no other transitions.
REQ-019 On IDLE->ACTIVE the block SHALL latch cpol_i and cpha_i, clear bit_cnt to 0 and load tx_sr from the transmit buffer, and SHALL ignore cpol_i/cpha_i changes until the next IDLE->ACTIVE.
REQ-020 Leading edge is a synchronized sclk transition away from the latched CPOL level; trailing edge is a transition back to it; sclk edges SHALL be ignored in IDLE.
REQ-021 The sample edge SHALL be the leading edge for CPHA=0 and the trailing edge for CPHA=1; the shift edge is the other edge.
REQ-022 On a sample edge the block SHALL shift synchronized mosi into rx_sr LSB (MSB first on the wire) and increment bit_cnt.
REQ-023 When bit_cnt reaches WordLength the block SHALL, in the same cycle, copy the completed word into dout_o, assert rx_valid_o for exactly one clk_i cycle and reset bit_cnt to 0.
REQ-024 On a shift edge with bit_cnt=0 the block SHALL load tx_sr from the transmit buffer; otherwise it SHALL shift tx_sr left by one; miso_o SHALL equal tx_sr MSB.
REQ-025 Consecutive words while ss_ni stays low SHALL be received and transmitted back to back with no gap bits.
REQ-026 load_i SHALL be accepted in any state; when load_i coincides with a tx_sr load, tx_sr SHALL take the old buffer value and the buffer SHALL take din_i.
REQ-027 Without an intervening load_i the buffer SHALL be retransmitted unchanged.
REQ-028 If ss_ni rises mid-word the block SHALL discard the partial word, keep dout_o unchanged, not pulse rx_valid_o and clear bit_cnt.
REQ-029 miso_oe_o SHALL equal busy_o; miso_o SHALL be 0 in IDLE.
REQ-030 rx_valid_o SHALL rise no later than 4 clk_i cycles after the final sample edge at the pin.

Reset
REQ-031 While rst_ni=0 the block SHALL hold state IDLE, all outputs 0 (dout_o, rx_valid_o, busy_o, miso_o, miso_oe_o), transmit buffer 0, bit_cnt 0 and synchronizers at ss=1 and sclk=0.
REQ-032 After reset release the block SHALL wait for a fresh ss_ni falling edge before it accepts sclk edges, including when ss_ni is already low at release.

Verification
REQ-033 Mode 0, load 0xA5C3F0, master sends 0x123456 -> miso bits form 0xA5C3F0, dout_o=0x123456, one rx_valid_o pulse.
REQ-034 Each of modes 1, 2 and 3 with 0x800001 each way -> exact match both directions in every mode.
REQ-035 Two back-to-back words under one ss_ni, load 0x111111 then 0x222222 between them -> master reads 0x111111 then 0x222222 and two rx_valid_o pulses.
REQ-036 ss_ni released after 10 bits -> no rx_valid_o, dout_o unchanged, next full frame 0xFFFFFF received correctly.
REQ-037 rst_ni pulsed low mid-frame -> outputs 0 immediately and no pulse until a new ss_ni falling edge.
REQ-038 load_i coinciding with the frame-start load -> old buffer sent in the current word and din_i in the next word.
